// File: rtl/xnor_sweep_checker.sv
// Sweep checker for a two-input XNOR unit: walks a/b through minterms 0..3,
// compares the unit's s and t outputs against ~(a^b), and reports the outcome.
module xnor_sweep_checker #(
    parameter int PASSES = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             s,
    input  logic             t,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       first_err_m,
    output logic             first_err_vld
);

    localparam int P_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(PASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       m_q;
    logic [P_W-1:0]   p_q;
    logic             a_q, b_q, busy_q, done_q, pass_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [1:0]       first_err_m_q;
    logic             first_err_vld_q;

    logic             exp_bit;
    logic             mismatch;
    logic [1:0]       m_inc;
    logic [CNT_W-1:0] err_cnt_d;

    // Both s and t wrong on one minterm still counts as a single mismatch.
    always_comb begin
        exp_bit   = ~(m_q[1] ^ m_q[0]);
        mismatch  = (s != exp_bit) || (t != exp_bit);
        m_inc     = m_q + 2'd1;
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            m_q             <= 2'd0;
            p_q             <= '0;
            a_q             <= 1'b0;
            b_q             <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_cnt_q       <= '0;
            first_err_m_q   <= 2'd0;
            first_err_vld_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q         <= ST_DRIVE;
                        m_q             <= 2'd0;
                        p_q             <= '0;
                        a_q             <= 1'b0;
                        b_q             <= 1'b0;
                        busy_q          <= 1'b1;
                        pass_q          <= 1'b0;
                        err_cnt_q       <= '0;
                        first_err_m_q   <= 2'd0;
                        first_err_vld_q <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    err_cnt_q <= err_cnt_d;
                    if (mismatch && !first_err_vld_q) begin
                        first_err_m_q   <= m_q;
                        first_err_vld_q <= 1'b1;
                    end
                    // m_inc wraps 3 -> 0, which is exactly the start of the next pass.
                    if (m_q != 2'd3) begin
                        state_q <= ST_DRIVE;
                        m_q     <= m_inc;
                        a_q     <= m_inc[1];
                        b_q     <= m_inc[0];
                    end else if (p_q != P_LAST) begin
                        state_q <= ST_DRIVE;
                        m_q     <= m_inc;
                        p_q     <= p_q + P_W'(1);
                        a_q     <= m_inc[1];
                        b_q     <= m_inc[0];
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a             = a_q;
    assign b             = b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_m   = first_err_m_q;
    assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_xnor_sweep_checker.sv
// Bench for xnor_sweep_checker: three configurations driven against a faultable
// XNOR unit model, with a per-cycle scoreboard of the stimulus/handshake outputs.
module tb_xnor_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int fault_mode = 0;
    int sel = 0;
    int tests_run = 0;
    int tests_failed = 0;

    logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic a0, b0, s0, t0, busy0, done0, pass0, vld0;
    logic a1, b1, s1, t1, busy1, done1, pass1, vld1;
    logic a2, b2, s2, t2, busy2, done2, pass2, vld2;
    logic [7:0] err0, err1;
    logic [1:0] err2;
    logic [1:0] fem0, fem1, fem2;

    // XNOR unit with selectable faults: 1 s stuck-1, 2 t=a^b, 3 s inverted,
    // 4 both s and t wrong only at minterm 2.
    function automatic logic [1:0] unit_model(input logic ia, input logic ib, input int mode);
        logic x, so, to;
        x  = ~(ia ^ ib);
        so = x;
        to = x;
        case (mode)
            1: so = 1'b1;
            2: to = ia ^ ib;
            3: so = ~x;
            4: if (ia && !ib) begin so = ~x; to = ~x; end
            default: ;
        endcase
        return {so, to};
    endfunction

    assign {s0, t0} = unit_model(a0, b0, fault_mode);
    assign {s1, t1} = unit_model(a1, b1, fault_mode);
    assign {s2, t2} = unit_model(a2, b2, fault_mode);

    xnor_sweep_checker #(.PASSES(1), .CNT_W(8)) u_p1 (
        .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .s(s0), .t(t0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_m(fem0), .first_err_vld(vld0));

    xnor_sweep_checker #(.PASSES(3), .CNT_W(8)) u_p3 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .s(s1), .t(t1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_m(fem1), .first_err_vld(vld1));

    xnor_sweep_checker #(.PASSES(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .s(s2), .t(t2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_m(fem2), .first_err_vld(vld2));

    logic       o_a, o_b, o_busy, o_done, o_pass, o_vld;
    logic [7:0] o_err;
    logic [1:0] o_fem;

    always_comb begin
        o_a = a0; o_b = b0; o_busy = busy0; o_done = done0;
        o_pass = pass0; o_vld = vld0; o_err = err0; o_fem = fem0;
        if (sel == 1) begin
            o_a = a1; o_b = b1; o_busy = busy1; o_done = done1;
            o_pass = pass1; o_vld = vld1; o_err = err1; o_fem = fem1;
        end else if (sel == 2) begin
            o_a = a2; o_b = b2; o_busy = busy2; o_done = done2;
            o_pass = pass2; o_vld = vld2; o_err = {6'b0, err2}; o_fem = fem2;
        end
    end

    typedef struct {
        int         dut;
        int         mode;
        int         ign1;
        int         ign2;
        logic       exp_pass;
        int         exp_err;
        logic [1:0] exp_fm;
        logic       exp_vld;
    } vec_t;

    typedef struct packed {
        logic a;
        logic b;
        logic busy;
        logic done;
    } cyc_t;

    cyc_t exp_q[$];
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int passes_of(input int d);
        return (d == 1) ? 3 : (d == 2) ? 2 : 1;
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            1: st1 = v;
            2: st2 = v;
            default: st0 = v;
        endcase
    endtask

    function automatic logic [15:0] all_outs(input int d);
        case (d)
            1: return {a1, b1, busy1, done1, pass1, vld1, fem1, err1};
            2: return {a2, b2, busy2, done2, pass2, vld2, fem2, 6'b0, err2};
            default: return {a0, b0, busy0, done0, pass0, vld0, fem0, err0};
        endcase
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int   np;
        cyc_t e, got;
        np = passes_of(v.dut);
        fault_mode = v.mode;
        sel = v.dut;
        @(negedge clk);
        set_start(v.dut, 1'b1);
        for (int j = 0; j <= 8 * np + 1; j++) begin
            e.a    = (j < 8 * np) ? (((j / 2) % 4) >= 2) : 1'b0;
            e.b    = (j < 8 * np) ? (((j / 2) % 2) == 1) : 1'b0;
            e.busy = (j <= 8 * np);
            e.done = (j == 8 * np);
            exp_q.push_back(e);
        end
        for (int j = 0; j <= 8 * np + 1; j++) begin
            @(posedge clk);
            #1;
            set_start(v.dut, (j == v.ign1) || (j == v.ign2));
            got = {o_a, o_b, o_busy, o_done};
            e = exp_q.pop_front();
            check($sformatf("vec%0d cyc%0d ab/busy/done", idx, j), 32'(got), 32'(e));
            if (j == 8 * np) begin
                check($sformatf("vec%0d pass", idx), 32'(o_pass), 32'(v.exp_pass));
                check($sformatf("vec%0d err_cnt", idx), 32'(o_err), 32'(v.exp_err));
                check($sformatf("vec%0d first_err", idx), {30'b0, o_vld, o_vld & o_fem[0]} | (32'(o_fem) << 4),
                      {30'b0, v.exp_vld, v.exp_vld & v.exp_fm[0]} | (32'(v.exp_fm) << 4));
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("vec%0d idle hold", idx), {21'b0, o_busy, o_pass, o_err},
              {21'b0, 1'b0, v.exp_pass, 8'(v.exp_err)});
        $display("[TB] vec%0d dut%0d mode%0d err_cnt=%0d pass=%0b", idx, v.dut, v.mode, o_err, o_pass);
    endtask

    initial begin
        int waited;
        bit seen_done;
        vecs[0] = '{0, 0, -1, -1, 1'b1, 0, 2'd0, 1'b0};
        vecs[1] = '{0, 1, -1, -1, 1'b0, 2, 2'd1, 1'b1};
        vecs[2] = '{0, 2, -1, -1, 1'b0, 4, 2'd0, 1'b1};
        vecs[3] = '{0, 4, -1, -1, 1'b0, 1, 2'd2, 1'b1};
        vecs[4] = '{1, 0,  5, 24, 1'b1, 0, 2'd0, 1'b0};
        vecs[5] = '{2, 3, -1, -1, 1'b0, 3, 2'd0, 1'b1};
        vecs[6] = '{1, 1, -1, -1, 1'b0, 6, 2'd1, 1'b1};

        #2;
        for (int d = 0; d < 3; d++) check($sformatf("reset outs dut%0d", d), 32'(all_outs(d)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a failing run: immediate clear, no done pulse.
        fault_mode = 1;
        sel = 0;
        @(negedge clk);
        st0 = 1'b1;
        @(posedge clk);
        #1;
        st0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid-run busy before reset", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-run reset outs", 32'(all_outs(0)), 32'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done0) seen_done = 1'b1;
        end
        check("no done after reset", 32'(seen_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(7, vecs[0]);

        // Start held high: the next run begins on the first IDLE cycle after DONE.
        fault_mode = 0;
        @(negedge clk);
        st0 = 1'b1;
        waited = 0;
        while (!done0 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("held start first done", 32'(done0), 32'd1);
        @(posedge clk);
        #1;
        check("held start idle gap", 32'(busy0), 32'd0);
        @(posedge clk);
        #1;
        check("held start rerun", {30'b0, busy0, a0 | b0}, 32'b10);
        st0 = 1'b0;
        waited = 0;
        while (!done0 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("held start second done", {31'b0, done0} | (32'(pass0) << 1), 32'b11);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xnor_sweep_checker.md
# xnor_sweep_checker

Self-checking sweep stage wrapped around the two-input XNOR function unit (outputs s = ~(a ^ b) and its NOR-only form t). On a start request it drives the unit's a/b inputs through all four minterms in order 0..3, samples s and t one cycle after each drive, and compares both against the expected XNOR value. Mismatches are counted and the first failing minterm is recorded. It sits directly upstream (stimulus) and downstream (result consumer) of the XNOR unit and replaces a hand-written truth-table sweep.

## Interface
- PASSES, 1, number of full 4-minterm sweeps per run (≥1)
- CNT_W, 8, width of the mismatch counter (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled in IDLE only
- a  out  1  stimulus to XNOR unit, = m[1]
- b  out  1  stimulus to XNOR unit, = m[0]
- s  in  1  XNOR unit output s (combinational from a, b)
- t  in  1  XNOR unit output t (combinational from a, b)
- busy  out  1  high in DRIVE/SAMPLE/DONE
- done  out  1  one-cycle pulse at end of run
- pass  out  1  run result, valid from done until next accepted start
- err_cnt  out  CNT_W  mismatching minterms this run, saturating
- first_err_m  out  2  minterm of first mismatch this run
- first_err_vld  out  1  first_err_m holds a valid capture

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, DRIVE, SAMPLE, DONE. Internal: minterm m (2 bits), pass counter p (0..PASSES-1).
- IDLE: a=b=0, busy=0. start=1 → DRIVE, m=0, p=0, err_cnt=0, first_err_vld=0, first_err_m=0, pass=0.
- DRIVE: a/b = m for one cycle (settling cycle) → SAMPLE.
- SAMPLE: a/b still = m. exp = ~(m[1]^m[0]). Mismatch if s≠exp or t≠exp; counts once per minterm even if both wrong. On mismatch: err_cnt += 1 unless at 2^CNT_W−1 (saturate); if first_err_vld=0, capture first_err_m=m, set first_err_vld.
- SAMPLE exit: m<3 → m+1, DRIVE. m=3 and p<PASSES−1 → m wraps to 0, p+1, DRIVE. m=3 and p=PASSES−1 → DONE.
- DONE: done=1 one cycle; pass = (err_cnt==0 including this final SAMPLE's result) registered; → IDLE. a=b=0 in DONE.
- start while busy: ignored, no effect on run or counters.
- start held high continuously: a new run begins on the first IDLE cycle after DONE.
- err_cnt, first_err_m, first_err_vld, pass hold their values in IDLE until the next accepted start.
- s/t sampled only in SAMPLE; values in other states are don't-care.

## Timing
- Reset (async assert): state=IDLE, m=0, p=0; a=b=0, busy=0, done=0, pass=0, err_cnt=0, first_err_m=0, first_err_vld=0. Deassertion takes effect on next clk edge.
- Reset mid-run: immediate abort to reset values; no done pulse.
- Run accepted at edge E0 (start=1 in IDLE): busy=1 from E0; DRIVE m=0 in cycle E0..E1.
- Each minterm occupies 2 cycles (DRIVE, SAMPLE); run = 8·PASSES cycles of DRIVE/SAMPLE.
- done high during cycle 8·PASSES after E0 (i.e. between edges E(8·PASSES) and E(8·PASSES+1)); pass/err_cnt final and stable in that cycle.
- IDLE re-entered at edge E(8·PASSES+1); busy=0 from there.
- err_cnt/first_err update at the edge ending SAMPLE; visible next cycle.
- All outputs registered; no combinational path from s/t to any output.

## Test plan
- Ideal XNOR model, PASSES=1, start pulse at E0 → a/b sequence 00,00,01,01,10,10,11,11; done at cycle 8; pass=1, err_cnt=0, first_err_vld=0.
- s stuck-at-1 → mismatches at m=1,2; err_cnt=2, first_err_m=1, first_err_vld=1, pass=0.
- t inverted (t=a^b), s correct → err_cnt=4, first_err_m=0, pass=0; both s and t wrong at one minterm counts 1.
- PASSES=3 ideal model → a/b cycle 00→11 three times, done at cycle 24, pass=1; start pulses at cycles 5 and 24 ignored.
- CNT_W=2, PASSES=2, s inverted → 8 mismatches, err_cnt saturates at 3, pass=0.
- rst_n low at cycle 5 of a run → all outputs 0 immediately, no done; fresh start afterwards completes normally with cleared err_cnt.
